smu_seq_unit: RTL

SMU_SEQ_UNIT -- requirements
Module: smu_seq_unit

---
 rtl/smu_seq_unit_if.sv | 43 ++++
 rtl/smu_seq_unit.sv | 89 ++++++++
 2 files changed

// File: rtl/smu_seq_unit_if.sv
// smu_seq_unit_if: configuration, observed-signal and status bundle for smu_seq_unit.
//   i            observed signal (K bits)
//   RegCmpMask   per-stage mask, stage s at [s*K +: K]
//   RegCmp       per-stage compare value, packed as RegCmpMask
//   RegCmpSel    per-stage op select, stage s at [2s +: 2] (00 ==, 01 <, 10 >, 11 !=)
//   RegLastStage index of the final stage
//   RegWindow    max cycles between stage matches (timeout build only)
//   SmuEn        matching enable
//   TrigClr      clears TrigSticky and TrigCount
//   SmuState     stage currently awaited
//   trigger      one-cycle pulse on full-sequence match
//   TrigSticky   set by trigger, held until TrigClr
//   TrigCount    saturating trigger count
//   Timeout      one-cycle pulse on window expiry
interface smu_seq_unit_if #(
    parameter int N = 4,
    parameter int K = 8,
    parameter int W = 8
);
    logic [K-1:0]         i;
    logic [N*K-1:0]       RegCmpMask;
    logic [N*K-1:0]       RegCmp;
    logic [2*N-1:0]       RegCmpSel;
    logic [$clog2(N)-1:0] RegLastStage;
    logic [W-1:0]         RegWindow;
    logic                 SmuEn;
    logic                 TrigClr;
    logic [$clog2(N)-1:0] SmuState;
    logic                 trigger;
    logic                 TrigSticky;
    logic [7:0]           TrigCount;
    logic                 Timeout;

    modport master (
        output i, RegCmpMask, RegCmp, RegCmpSel, RegLastStage, RegWindow, SmuEn, TrigClr,
        input  SmuState, trigger, TrigSticky, TrigCount, Timeout
    );

    modport slave (
        input  i, RegCmpMask, RegCmp, RegCmpSel, RegLastStage, RegWindow, SmuEn, TrigClr,
        output SmuState, trigger, TrigSticky, TrigCount, Timeout
    );
endinterface

// File: rtl/smu_seq_unit.sv
// smu_seq_unit: N-stage sequential match unit raising a trigger when every stage hits in order.
//   gated_clk  block clock (gated upstream)
//   reset      synchronous, active-high reset
//   bus        smu_seq_unit_if.slave: configuration, observed signal i, status outputs
// Optional feature: define SMU_SEQ_TIMEOUT_EN to add the inter-stage window counter
// and the Timeout pulse; otherwise partial progress is held indefinitely and Timeout is 0.
module smu_seq_unit #(
    parameter int N = 4,
    parameter int K = 8,
    parameter int W = 8
) (
    input logic           gated_clk,
    input logic           reset,
    smu_seq_unit_if.slave bus
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] state_q, state_d, last_eff;
    logic          trig_q, trig_d, sticky_q, sticky_d, to_q, to_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [K-1:0]  a, b;
    logic [1:0]    sel;
    logic          hit, at_last, fire, adv, expire;

    assign last_eff = (bus.RegLastStage > SW'(N - 1)) ? SW'(N - 1) : bus.RegLastStage;
    assign a        = bus.i & bus.RegCmpMask[state_q*K +: K];
    assign b        = bus.RegCmp[state_q*K +: K] & bus.RegCmpMask[state_q*K +: K];
    assign sel      = bus.RegCmpSel[2*state_q +: 2];
    assign hit      = (sel == 2'b00) ? (a == b) :
                      (sel == 2'b01) ? (a < b)  :
                      (sel == 2'b10) ? (a > b)  : (a != b);
    // A state beyond a freshly lowered last stage is treated as the last stage.
    assign at_last  = state_q >= last_eff;
    assign fire     = bus.SmuEn & hit & at_last;
    assign adv      = bus.SmuEn & hit & ~at_last;

`ifdef SMU_SEQ_TIMEOUT_EN
    logic [W-1:0] win_q, win_d;
    logic         miss_wait;
    // A zero counter means an unlimited window, so it never counts down or expires.
    assign miss_wait = bus.SmuEn & ~hit & (state_q != '0) & (win_q != '0);
    assign expire    = miss_wait & (win_q == W'(1));
    always_comb begin
        win_d = adv ? bus.RegWindow :
                (fire | expire) ? '0 :
                miss_wait ? win_q - W'(1) : win_q;
    end
    always_ff @(posedge gated_clk) begin
        if (reset) win_q <= '0;
        else       win_q <= win_d;
    end
`else
    logic unused_window;
    assign unused_window = ^bus.RegWindow;
    assign expire        = 1'b0;
`endif

    always_comb begin
        state_d  = (fire | expire) ? '0 : adv ? state_q + SW'(1) : state_q;
        trig_d   = fire;
        to_d     = expire;
        // A clear coinciding with a trigger leaves the new trigger recorded.
        sticky_d = fire | (sticky_q & ~bus.TrigClr);
        cnt_d    = bus.TrigClr ? {7'b0, fire} :
                   (fire && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge gated_clk) begin
        if (reset) begin
            state_q  <= '0;
            trig_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            trig_q   <= trig_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
        end
    end

    assign bus.SmuState   = state_q;
    assign bus.trigger    = trig_q;
    assign bus.TrigSticky = sticky_q;
    assign bus.TrigCount  = cnt_q;
    assign bus.Timeout    = to_q;
endmodule
